pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Produces per-register enable and flush (bubble) controls from three event sources: load-use hazards, data-memory wait handshakes and taken branches.
- Contains a 3-state FSM, a branch-penalty counter, a memory-timeout watchdog and a saturating stall performance counter.

Parameters:
REG_ADDR_W, 4, width of register-file addresses
BRANCH_PENALTY, 2, number of consecutive cycles IF/ID and ID/EX are flushed after a taken branch (>=1)
MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before mem_error asserts (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_rs1  input  REG_ADDR_W  source reg 1 of instruction in ID
id_rs2  input  REG_ADDR_W  source reg 2 of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_ADDR_W  destination reg of instruction in EX
mem_req  input  1  MEM stage has an active data-memory access
mem_ready  input  1  data memory completes access this cycle
branch_taken  input  1  EX resolves a taken branch this cycle
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads NOP
idex_en  output  1  ID/EX load enable
idex_flush  output  1  ID/EX loads NOP (wbs=0, mem write=0)
exmem_en  output  1  EX/MEM load enable
memwb_flush  output  1  MEM/WB loads bubble (wbs=0)
mem_error  output  1  sticky memory-timeout flag
stall_cycles  output  16  saturating count of cycles with pc_en=0

Behaviour:
- Reset (async, rst=1): state=RUN, branch counter=0, timeout counter=0, mem_error=0, stall_cycles=0. While rst=1 all enables=0 and all flushes=0. First edge after release: normal RUN decode.
- Control outputs are combinational decodes of state and inputs. mem_error and stall_cycles are registered.
- Definitions:
  - mem_stall = mem_req & ~mem_ready.
  - load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Default when no event applies: all enables=1, all flushes=0.
- RUN, priority mem_stall > branch_taken > load_use:
  - mem_stall: pc_en, ifid_en, idex_en and exmem_en all 0; memwb_flush=1. Next state MEM_WAIT; timeout counter=1.
  - branch_taken: all enables=1; ifid_flush=1 and idex_flush=1. If BRANCH_PENALTY>1, next state BR_FLUSH with counter=BRANCH_PENALTY-1; otherwise stay in RUN.
  - load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Single-cycle response; the bubble clears the hazard and the FSM stays in RUN.
- MEM_WAIT:
  - While mem_ready=0: freeze outputs as in the RUN mem_stall case; timeout counter increments, saturating at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_error sets on that edge. It stays set until rst; the FSM keeps waiting.
  - mem_ready=1: default outputs, next state RUN, timeout counter cleared.
  - branch_taken and load_use are ignored in this state.
- BR_FLUSH:
  - Normal cycles: ifid_flush=1, idex_flush=1, all enables=1; counter decrements, and the FSM returns to RUN when the counter goes 1 -> 0.
  - mem_stall in this state: outputs as in the mem_stall case with no flushes, and the counter holds. No state change; the timeout counter does not run here.
  - branch_taken in this state is ignored.
- stall_cycles: increments every clock edge where pc_en=0 and rst=0; saturates at 0xFFFF.
- Simultaneous mem_stall and branch_taken in RUN: mem_stall wins. branch_taken must be re-presented by EX, which is frozen, after the wait ends.

Test Plan:
- Reset: assert rst mid-MEM_WAIT with mem_error=1 -> all enables=0, flushes=0, mem_error=0, stall_cycles=0 immediately. After release with no events -> all enables=1.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_use_rs1=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cycles 0->1. Same with ex_rd=0 -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> 3 cycles of all enables=0 and memwb_flush=1, then enables=1 and state RUN; stall_cycles=3.
- Branch: branch_taken=1 one cycle with BRANCH_PENALTY=2 -> ifid_flush and idex_flush high for exactly 2 cycles, pc_en=1 throughout. A branch_taken pulse during the 2nd cycle does not extend the flush.
- Timeout: mem_stall held 64 cycles (MEM_TIMEOUT=64) -> mem_error rises at the 64th edge in MEM_WAIT and stays high after mem_ready=1.
- Priority: mem_stall, branch_taken and load_use all in the same RUN cycle -> mem_stall response only, next state MEM_WAIT, no flush of IF/ID or ID/EX.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory
// wait freezes and taken-branch flushes, with a memory watchdog and stall counter.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_W     = 4,
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter int unsigned MEM_TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_flush,
    output logic                  exmem_en,
    output logic                  memwb_flush,
    output logic                  mem_error,
    output logic [15:0]           stall_cycles
);

    localparam int unsigned BR_W    = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;
    localparam int unsigned TMO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_BR_FLUSH = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [BR_W-1:0]    br_cnt, br_next;
    logic [TMO_W-1:0]   tmo_cnt, tmo_next;
    logic               err_set;
    logic               mem_stall;
    logic               load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rd != '0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    // Next-state and control decode
    always_comb begin
        state_next  = state;
        br_next     = br_cnt;
        tmo_next    = tmo_cnt;
        err_set     = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;

        case (state)
            S_RUN: begin
                if (mem_stall) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                    state_next  = S_MEM_WAIT;
                    tmo_next    = TMO_W'(1);
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_next = S_BR_FLUSH;
                        br_next    = BR_W'(BRANCH_PENALTY - 1);
                    end
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                    if (tmo_cnt < TMO_W'(MEM_TIMEOUT)) begin
                        tmo_next = tmo_cnt + TMO_W'(1);
                    end
                    err_set = (tmo_next == TMO_W'(MEM_TIMEOUT));
                end else begin
                    state_next = S_RUN;
                    tmo_next   = '0;
                end
            end
            S_BR_FLUSH: begin
                if (mem_stall) begin
                    // Freeze without flushing; the remaining penalty is kept
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    br_next    = br_cnt - BR_W'(1);
                    if (br_cnt <= BR_W'(1)) begin
                        state_next = S_RUN;
                        br_next    = '0;
                    end
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b0;
        end
    end

    // State, counters and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            br_cnt       <= '0;
            tmo_cnt      <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state   <= state_next;
            br_cnt  <= br_next;
            tmo_cnt <= tmo_next;
            if (err_set) begin
                mem_error <= 1'b1;
            end
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vector bench for pipeline_hazard_controller: RUN-state decode table
// plus hand-written memory-wait, branch, priority, timeout and reset sequences.
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read;
    logic        mem_req, mem_ready, branch_taken;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic        mem_error;
    logic [15:0] stall_cycles;
    logic [6:0]  ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stalls = 0;
    logic exp_err = 1'b0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
    localparam logic [6:0] C_RUN   = 7'b1101010;
    localparam logic [6:0] C_LU    = 7'b0001110;
    localparam logic [6:0] C_MEM   = 7'b0000001;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_RESET = 7'b0000000;

    assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};

    pipeline_hazard_controller #(
        .REG_ADDR_W(4), .BRANCH_PENALTY(2), .MEM_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_flush(memwb_flush), .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       use1;
        logic       use2;
        logic       mrd;
        logic [3:0] rd;
        logic       mreq;
        logic       mrdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    // One cycle: check decode and registered outputs at negedge, then clock.
    task automatic step(input string nm, input logic [6:0] exp);
        @(negedge clk);
        chk({nm, " ctrl"}, 32'(ctrl), 32'(exp));
        chk({nm, " stall_cycles"}, 32'(stall_cycles), 32'(exp_stalls));
        chk({nm, " mem_error"}, 32'(mem_error), 32'(exp_err));
        @(posedge clk);
        if (!exp[6]) exp_stalls++;
        #1;
    endtask

    initial begin
        vecs[0] = '{"idle",          4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, C_RUN};
        vecs[1] = '{"lu_rs1",        4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, C_LU};
        vecs[2] = '{"lu_rd0",        4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, C_RUN};
        vecs[3] = '{"lu_rs2",        4'd1, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, C_LU};
        vecs[4] = '{"rs2_unused",    4'd1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, C_RUN};
        vecs[5] = '{"no_load",       4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, C_RUN};
        vecs[6] = '{"mem_ready_hit", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, C_RUN};

        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("reset ctrl", 32'(ctrl), 32'(C_RESET));
        chk("reset mem_error", 32'(mem_error), 32'd0);
        chk("reset stall_cycles", 32'(stall_cycles), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // RUN-state decode table
        for (int i = 0; i < 7; i++) begin
            id_rs1 = vecs[i].rs1;  id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
            ex_mem_read = vecs[i].mrd; ex_rd = vecs[i].rd;
            mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            branch_taken = 1'b0;
            step(vecs[i].name, vecs[i].exp);
        end
        clear_inputs();
        step("after_table", C_RUN);

        // Three-cycle memory wait; branch during the wait is ignored
        mem_req = 1'b1; mem_ready = 1'b0;
        step("mw_1", C_MEM);
        branch_taken = 1'b1;
        step("mw_2", C_MEM);
        branch_taken = 1'b0;
        step("mw_3", C_MEM);
        mem_ready = 1'b1;
        step("mw_done", C_RUN);
        clear_inputs();
        step("mw_back_run", C_RUN);

        // Branch: exactly two flush cycles, second-cycle branch does not extend
        branch_taken = 1'b1;
        step("br_1", C_BR);
        step("br_2_repulse", C_BR);
        branch_taken = 1'b0;
        step("br_end", C_RUN);

        // Memory stall inside the branch penalty holds the remaining flush
        branch_taken = 1'b1;
        step("brm_1", C_BR);
        branch_taken = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        step("brm_stall", C_MEM);
        mem_ready = 1'b1;
        step("brm_2", C_BR);
        clear_inputs();
        step("brm_end", C_RUN);

        // Priority: mem_stall beats branch and load-use in the same cycle
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; id_use_rs1 = 1'b1;
        step("prio_stall", C_MEM);
        mem_ready = 1'b1;
        step("prio_wait_exit", C_RUN);
        clear_inputs();
        step("prio_no_brflush", C_RUN);

        // Watchdog: 64th consecutive stall edge sets the sticky error
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 66; i++) begin
            exp_err = (i > 64);
            step($sformatf("tmo_%0d", i), C_MEM);
        end
        mem_ready = 1'b1;
        step("tmo_release", C_RUN);
        clear_inputs();
        step("tmo_sticky", C_RUN);

        // Asynchronous reset in the middle of a memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        step("rst_enter_wait", C_MEM);
        @(negedge clk);
        chk("rst_pre ctrl", 32'(ctrl), 32'(C_MEM));
        chk("rst_pre mem_error", 32'(mem_error), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async ctrl", 32'(ctrl), 32'(C_RESET));
        chk("rst_async mem_error", 32'(mem_error), 32'd0);
        chk("rst_async stall_cycles", 32'(stall_cycles), 32'd0);
        exp_err = 1'b0;
        exp_stalls = 0;
        clear_inputs();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_reset_1", C_RUN);
        step("post_reset_2", C_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
